ws_block_writeback: RTL and testbench

//  Parametrised successor to the per-block S-matrix write-back stage. It reads one BLK_DIM x BLK_DIM block of

---
 rtl/ws_pkg.sv | 26 ++
 rtl/ws_addr_gen.sv | 42 ++++
 rtl/ws_block_writeback.sv | 186 ++++++++++++++++++
 tb/tb_ws_block_writeback.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ws_pkg.sv
// Shared types and helpers for the S-matrix block write-back stage.
package ws_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRIME,
        STREAM,
        DRAIN,
        ADVANCE
    } ws_wb_state_t;

    typedef logic [1:0] plane_t;

    function automatic logic [7:0] clip8(input logic signed [15:0] v);
        if (v < 16'sd0)
            return 8'h00;
        else if (v > 16'sd255)
            return 8'hFF;
        return v[7:0];
    endfunction

    function automatic logic is_clipped(input logic signed [15:0] v);
        return (v < 16'sd0) || (v > 16'sd255);
    endfunction

endpackage

// File: rtl/ws_addr_gen.sv
// SRAM word address of a sample pair: plane base + block row/col offset + in-block position.
module ws_addr_gen
    import ws_pkg::*;
#(
    parameter int BLK_DIM    = 8,
    parameter int Y_BLK_COLS = 40,
    parameter int C_BLK_COLS = 20,
    parameter int Y_BASE     = 0,
    parameter int U_BASE     = 38400,
    parameter int V_BASE     = 57600,
    parameter int RB_W       = 5,
    parameter int CB_W       = 6,
    localparam int L         = $clog2(BLK_DIM)
) (
    input  plane_t            plane_i,
    input  logic [RB_W-1:0]   rb_i,
    input  logic [CB_W-1:0]   cb_i,
    input  logic [L-1:0]      r_i,
    input  logic [L-2:0]      c_half_i,
    output logic [17:0]       addr_o
);
    localparam int Y_RW = Y_BLK_COLS * BLK_DIM / 2;
    localparam int C_RW = C_BLK_COLS * BLK_DIM / 2;

    logic [17:0] row, row_off, col_off, base;

    // BLK_DIM is a power of two, so RB*BLK_DIM + r and CB*BLK_DIM/2 + c/2 are plain concatenations.
    assign row     = 18'({rb_i, r_i});
    assign col_off = 18'({cb_i, c_half_i});
    assign row_off = (plane_i == 2'd0) ? row * 18'(Y_RW) : row * 18'(C_RW);

    always_comb begin
        case (plane_i)
            2'd0:    base = 18'(Y_BASE);
            2'd1:    base = 18'(U_BASE);
            default: base = 18'(V_BASE);
        endcase
    end

    assign addr_o = base + row_off + col_off;

endmodule

// File: rtl/ws_block_writeback.sv
// Reads one S block, descales/clips to 8 bits, packs sample pairs and writes them to SRAM.
// Optional WS_SAT_COUNT_EN builds a saturating count of clipped samples.
module ws_block_writeback
    import ws_pkg::*;
#(
    parameter int BLK_DIM    = 8,
    parameter int Y_BLK_COLS = 40,
    parameter int C_BLK_COLS = 20,
    parameter int BLK_ROWS   = 30,
    parameter int NUM_PLANES = 3,
    parameter int Y_BASE     = 0,
    parameter int U_BASE     = 38400,
    parameter int V_BASE     = 57600,
    parameter int FRAC_SHIFT = 8,
    localparam int SA_W      = (2 * $clog2(BLK_DIM) > 7) ? 2 * $clog2(BLK_DIM) : 7
) (
    input  logic            CLOCK_50_I,
    input  logic            Resetn,
    input  logic            WS_start,
    output logic            WS_done,
    output logic            WS_memory_end,
    output plane_t          WS_plane,
    output logic [SA_W-1:0] S_read_address,
    input  logic [31:0]     S_read_data,
    output logic            S_write_enable,
    output logic [17:0]     SRAM_address,
    output logic            SRAM_we_n,
    output logic [15:0]     SRAM_write_data,
    output logic [15:0]     WS_sat_count
);
    localparam int L     = $clog2(BLK_DIM);
    localparam int IW    = 2 * L;
    localparam int MAXC  = (Y_BLK_COLS > C_BLK_COLS) ? Y_BLK_COLS : C_BLK_COLS;
    localparam int CB_W  = $clog2(MAXC + 1);
    localparam int RB_W  = $clog2(BLK_ROWS + 1);

    ws_wb_state_t    state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d, idx_nx;
    logic [CB_W-1:0] cb_q, cb_d;
    logic [RB_W-1:0] rb_q, rb_d;
    plane_t          plane_q, plane_d;
    logic            mem_end_q, mem_end_d;
    logic [7:0]      buf_q, buf_d;
    logic            we_n_q, we_n_d;
    logic [17:0]     addr_q, addr_d, gen_addr;
    logic [15:0]     data_q, data_d;
    logic            last_col, last_row, last_pl, last_blk;
    logic signed [15:0] samp;
    logic            unused_sdata;

    assign samp         = S_read_data[FRAC_SHIFT+15:FRAC_SHIFT];
    assign unused_sdata = ^S_read_data;
    assign idx_nx       = idx_q + 1'b1;

    assign last_col = (plane_q == 2'd0) ? (cb_q == CB_W'(Y_BLK_COLS - 1))
                                        : (cb_q == CB_W'(C_BLK_COLS - 1));
    assign last_row = (rb_q == RB_W'(BLK_ROWS - 1));
    assign last_pl  = (plane_q == 2'(NUM_PLANES - 1));
    assign last_blk = last_col && last_row && last_pl;

    ws_addr_gen #(
        .BLK_DIM(BLK_DIM), .Y_BLK_COLS(Y_BLK_COLS), .C_BLK_COLS(C_BLK_COLS),
        .Y_BASE(Y_BASE), .U_BASE(U_BASE), .V_BASE(V_BASE), .RB_W(RB_W), .CB_W(CB_W)
    ) u_addr (
        .plane_i  (plane_q),
        .rb_i     (rb_q),
        .cb_i     (cb_q),
        .r_i      (idx_q[IW-1:L]),
        .c_half_i (idx_q[L-1:1]),
        .addr_o   (gen_addr)
    );

    always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
        if (!Resetn) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (WS_start && !mem_end_q) state_d = PRIME;
            PRIME:   state_d = STREAM;
            STREAM:  if (idx_q == IW'(BLK_DIM * BLK_DIM - 1)) state_d = DRAIN;
            DRAIN:   state_d = ADVANCE;
            ADVANCE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        WS_done        = (state_q == ADVANCE);
        WS_memory_end  = mem_end_q || (state_q == ADVANCE && last_blk);
        S_read_address = (state_q == STREAM) ? SA_W'(idx_nx) : '0;
    end

    // idx_q names the sample on S_read_data; the read for idx_q+1 is already in flight.
    always_comb begin
        idx_d     = '0;
        buf_d     = buf_q;
        we_n_d    = 1'b1;
        addr_d    = addr_q;
        data_d    = data_q;
        cb_d      = cb_q;
        rb_d      = rb_q;
        plane_d   = plane_q;
        mem_end_d = mem_end_q;
        case (state_q)
            STREAM: begin
                idx_d = idx_nx;
                if (idx_q[0]) begin
                    we_n_d = 1'b0;
                    addr_d = gen_addr;
                    data_d = {buf_q, clip8(samp)};
                end else begin
                    buf_d = clip8(samp);
                end
            end
            ADVANCE: begin
                // The final block of the frame leaves the counters parked on it.
                if (!last_col) begin
                    cb_d = cb_q + 1'b1;
                end else if (!last_row) begin
                    cb_d = '0;
                    rb_d = rb_q + 1'b1;
                end else if (!last_pl) begin
                    cb_d    = '0;
                    rb_d    = '0;
                    plane_d = plane_q + 2'd1;
                end else begin
                    mem_end_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
        if (!Resetn) begin
            idx_q     <= '0;
            cb_q      <= '0;
            rb_q      <= '0;
            plane_q   <= '0;
            mem_end_q <= 1'b0;
            buf_q     <= '0;
            we_n_q    <= 1'b1;
            addr_q    <= '0;
            data_q    <= '0;
        end else begin
            idx_q     <= idx_d;
            cb_q      <= cb_d;
            rb_q      <= rb_d;
            plane_q   <= plane_d;
            mem_end_q <= mem_end_d;
            buf_q     <= buf_d;
            we_n_q    <= we_n_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
        end
    end

    assign WS_plane        = plane_q;
    assign S_write_enable  = 1'b0;
    assign SRAM_address    = addr_q;
    assign SRAM_we_n       = we_n_q;
    assign SRAM_write_data = data_q;

`ifdef WS_SAT_COUNT_EN
    logic [15:0] sat_q, sat_d;

    always_comb begin
        sat_d = sat_q;
        if (state_q == STREAM && is_clipped(samp) && sat_q != 16'hFFFF)
            sat_d = sat_q + 16'd1;
    end

    always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
        if (!Resetn) sat_q <= '0;
        else         sat_q <= sat_d;
    end

    assign WS_sat_count = sat_q;
`else
    assign WS_sat_count = 16'd0;
`endif

endmodule

// File: tb/tb_ws_block_writeback.sv
// Directed bench: default instance (A), 4x4 single-plane instance (B), tiny 3-plane frame instance (C).
module tb_ws_block_writeback;

    logic        clk = 1'b0;
    logic        rst_n [3];
    logic        start [3];
    logic        done  [3];
    logic        mend  [3];
    logic [1:0]  plane [3];
    logic [6:0]  sra   [3];
    logic [31:0] srd   [3];
    logic        swe   [3];
    logic [17:0] sa    [3];
    logic        we_n  [3];
    logic [15:0] wd    [3];
    logic [15:0] sat   [3];

    logic [31:0] smem [3][0:127];
    logic [17:0] wa   [3][0:2047];
    logic [15:0] wdat [3][0:2047];
    int          wcnt [3] = '{default: 0};
    int          dcnt [3] = '{default: 0};
    int          b2b  [3] = '{default: 0};
    logic        prev_we [3] = '{default: 1'b1};

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [31:0] din;
        logic [7:0]  pix;
        int          clipped;
    } vec_t;
    vec_t tv [8];

    always #10 clk = ~clk;

    ws_block_writeback dut_a (
        .CLOCK_50_I(clk), .Resetn(rst_n[0]), .WS_start(start[0]), .WS_done(done[0]),
        .WS_memory_end(mend[0]), .WS_plane(plane[0]), .S_read_address(sra[0]),
        .S_read_data(srd[0]), .S_write_enable(swe[0]), .SRAM_address(sa[0]),
        .SRAM_we_n(we_n[0]), .SRAM_write_data(wd[0]), .WS_sat_count(sat[0]));

    ws_block_writeback #(.BLK_DIM(4), .NUM_PLANES(1), .BLK_ROWS(2)) dut_b (
        .CLOCK_50_I(clk), .Resetn(rst_n[1]), .WS_start(start[1]), .WS_done(done[1]),
        .WS_memory_end(mend[1]), .WS_plane(plane[1]), .S_read_address(sra[1]),
        .S_read_data(srd[1]), .S_write_enable(swe[1]), .SRAM_address(sa[1]),
        .SRAM_we_n(we_n[1]), .SRAM_write_data(wd[1]), .WS_sat_count(sat[1]));

    ws_block_writeback #(.BLK_DIM(4), .Y_BLK_COLS(4), .C_BLK_COLS(2), .BLK_ROWS(2),
                         .NUM_PLANES(3), .Y_BASE(0), .U_BASE(1000), .V_BASE(2000)) dut_c (
        .CLOCK_50_I(clk), .Resetn(rst_n[2]), .WS_start(start[2]), .WS_done(done[2]),
        .WS_memory_end(mend[2]), .WS_plane(plane[2]), .S_read_address(sra[2]),
        .S_read_data(srd[2]), .S_write_enable(swe[2]), .SRAM_address(sa[2]),
        .SRAM_we_n(we_n[2]), .SRAM_write_data(wd[2]), .WS_sat_count(sat[2]));

    // Synchronous-read S RAM models
    always @(posedge clk)
        for (int i = 0; i < 3; i++) srd[i] <= smem[i][sra[i]];

    // Write / done monitor, sampled on the falling edge
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!we_n[i]) begin
                if (wcnt[i] < 2048) begin
                    wa[i][wcnt[i]]   <= sa[i];
                    wdat[i][wcnt[i]] <= wd[i];
                end
                wcnt[i] <= wcnt[i] + 1;
                if (!prev_we[i]) b2b[i] <= b2b[i] + 1;
            end
            prev_we[i] <= we_n[i];
            if (done[i]) dcnt[i] <= dcnt[i] + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Launch one block; lat = cycles from the sampling edge to WS_done, -1 on timeout.
    task automatic run_block(input int d, output int lat, output logic me);
        int n = 0;
        lat = -1;
        me  = 1'b0;
        start[d] = 1'b1;
        while (n < 400) begin
            @(posedge clk); #1; n++;
            start[d] = 1'b0;
            if (done[d]) begin
                lat = n;
                me  = mend[d];
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic idle_start(input int d);
        int w0 = wcnt[d];
        int d0 = dcnt[d];
        start[d] = 1'b1;
        repeat (60) @(posedge clk);
        #1;
        start[d] = 1'b0;
        chk($sformatf("ignored_start_writes[%0d]", d), wcnt[d] - w0, 0);
        chk($sformatf("ignored_start_done[%0d]", d), dcnt[d] - d0, 0);
        chk($sformatf("mem_end_sticky[%0d]", d), mend[d], 1);
    endtask

    function automatic int exp_addr(int base, int rw, int bd, int rb, int cb, int j);
        int s = 2 * j;
        return base + (rb * bd + s / bd) * rw + cb * bd / 2 + (s % bd) / 2;
    endfunction

    initial begin
        int   lat, b, s0, errs, exp_sat, ebase, erw, erb, ecb, epl;
        logic me;
        logic [7:0] byt;

        tv[0] = '{32'h0000_0000, 8'h00, 0};
        tv[1] = '{32'h0000_0100, 8'h01, 0};
        tv[2] = '{32'h0000_FF00, 8'hFF, 0};
        tv[3] = '{32'h0001_0000, 8'hFF, 1};
        tv[4] = '{32'h0001_2300, 8'hFF, 1};
        tv[5] = '{32'hFFFF_FF00, 8'h00, 1};
        tv[6] = '{32'h0080_0000, 8'h00, 1};
        tv[7] = '{32'hFF00_7F80, 8'h7F, 0};

        for (int i = 0; i < 3; i++) begin
            rst_n[i] = 1'b0;
            start[i] = 1'b0;
            for (int k = 0; k < 128; k++) smem[i][k] = 32'(k) << 8;
        end

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_we_n", we_n[0], 1);
        chk("rst_done", done[0], 0);
        chk("rst_mem_end", mend[0], 0);
        chk("rst_plane", plane[0], 0);
        chk("rst_sram_addr", sa[0], 0);
        chk("rst_sram_data", wd[0], 0);
        chk("rst_sat", sat[0], 0);
        chk("rst_s_we", swe[0], 0);
        chk("rst_s_addr", sra[0], 0);
        for (int i = 0; i < 3; i++) rst_n[i] = 1'b1;
        @(posedge clk); #1;

        // T1: ramp data, first block
        b = wcnt[0];
        run_block(0, lat, me);
        chk("t1_latency", lat, 67);
        chk("t1_writes", wcnt[0] - b, 32);
        for (int j = 0; j < 32; j++) begin
            chk($sformatf("t1_addr[%0d]", j), wa[0][b + j], exp_addr(0, 160, 8, 0, 0, j));
            chk($sformatf("t1_data[%0d]", j), wdat[0][b + j], {8'(2 * j), 8'(2 * j + 1)});
        end

        // T2: clip table on samples 0..7, rest zero
        s0 = sat[0];
        exp_sat = 0;
        for (int k = 0; k < 64; k++) smem[0][k] = 32'h0;
        for (int t = 0; t < 8; t++) begin
            smem[0][t] = tv[t].din;
            exp_sat += tv[t].clipped;
        end
`ifndef WS_SAT_COUNT_EN
        exp_sat = 0;
`endif
        b = wcnt[0];
        run_block(0, lat, me);
        chk("t2_latency", lat, 67);
        chk("t2_first_addr", wa[0][b], 4);
        for (int t = 0; t < 8; t++) begin
            byt = (t % 2 == 0) ? wdat[0][b + t / 2][15:8] : wdat[0][b + t / 2][7:0];
            chk($sformatf("t2_clip[%0d]", t), byt, tv[t].pix);
        end
        chk("t2_sat_delta", sat[0] - s0, exp_sat);

        // T3 (partial): blocks 2..40 of plane 0
        errs = 0;
        for (int blk = 2; blk <= 40; blk++) begin
            b = wcnt[0];
            run_block(0, lat, me);
            if (lat != 67 || me) errs++;
        end
        chk("t3_block_errs", errs, 0);
        chk("t3_blk40_first", wa[0][b], 1280);
        chk("t3_blk40_last", wa[0][b + 31], exp_addr(0, 160, 8, 1, 0, 31));
        chk("t3_plane", plane[0], 0);

        // T5: reset during STREAM cycle 20
        start[0] = 1'b1;
        for (int n = 1; n <= 22; n++) begin
            @(posedge clk); #1;
            start[0] = 1'b0;
        end
        chk("t5_write_before_rst", we_n[0], 0);
        rst_n[0] = 1'b0;
        #1;
        chk("t5_we_n_async", we_n[0], 1);
        chk("t5_addr_async", sa[0], 0);
        chk("t5_sat_async", sat[0], 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n[0] = 1'b1;
        for (int k = 0; k < 64; k++) smem[0][k] = 32'(k) << 8;
        @(posedge clk); #1;
        b = wcnt[0];
        run_block(0, lat, me);
        chk("t5_latency", lat, 67);
        chk("t5_writes", wcnt[0] - b, 32);
        chk("t5_first_addr", wa[0][b], 0);
        chk("t5_first_data", wdat[0][b], 16'h0001);

        // T6: BLK_DIM=4, single plane, ROW_WORDS=80
        b = wcnt[1];
        run_block(1, lat, me);
        chk("t6_latency", lat, 19);
        chk("t6_writes", wcnt[1] - b, 8);
        for (int j = 0; j < 8; j++) begin
            chk($sformatf("t6_addr[%0d]", j), wa[1][b + j], exp_addr(0, 80, 4, 0, 0, j));
            chk($sformatf("t6_data[%0d]", j), wdat[1][b + j], {8'(2 * j), 8'(2 * j + 1)});
        end
        errs = 0;
        for (int blk = 1; blk < 80; blk++) begin
            if (blk == 79) chk("t6_mem_end_before_last", mend[1], 0);
            b = wcnt[1];
            run_block(1, lat, me);
            if (blk < 79 && (lat != 19 || me)) errs++;
        end
        chk("t6_block_errs", errs, 0);
        chk("t6_last_first_addr", wa[1][b], exp_addr(0, 80, 4, 1, 39, 0));
        chk("t6_mem_end_with_done", me, 1);
        chk("t6_plane_hold", plane[1], 0);
        idle_start(1);

        // T3/T4 on a small frame: plane bases, plane index, memory end
        for (int blk = 0; blk < 16; blk++) begin
            if (blk < 8) begin
                epl = 0; ebase = 0;    erw = 8; erb = blk / 4;        ecb = blk % 4;
            end else if (blk < 12) begin
                epl = 1; ebase = 1000; erw = 4; erb = (blk - 8) / 2;  ecb = (blk - 8) % 2;
            end else begin
                epl = 2; ebase = 2000; erw = 4; erb = (blk - 12) / 2; ecb = (blk - 12) % 2;
            end
            chk($sformatf("fr_plane[%0d]", blk), plane[2], epl);
            b = wcnt[2];
            run_block(2, lat, me);
            chk($sformatf("fr_first[%0d]", blk), wa[2][b], exp_addr(ebase, erw, 4, erb, ecb, 0));
            chk($sformatf("fr_last[%0d]", blk), wa[2][b + 7], exp_addr(ebase, erw, 4, erb, ecb, 7));
            chk($sformatf("fr_mem_end[%0d]", blk), me, (blk == 15) ? 1 : 0);
        end
        idle_start(2);
        chk("fr_plane_final", plane[2], 2);

        for (int i = 0; i < 3; i++)
            chk($sformatf("no_back_to_back[%0d]", i), b2b[i], 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
